// File: rtl/simon_pkg.sv
// Shared types and width helpers for the Simon sequence controller.
// The state encoding is fixed at 4 bits so it can be probed on a debug bus.
package simon_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GEN,
        ST_SHOW_ON,
        ST_SHOW_GAP,
        ST_PLAYER,
        ST_CHECK,
        ST_LEVEL_UP,
        ST_WIN,
        ST_ERROR
    } state_t;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cw_of(input int num_colors);
        return width_of(num_colors);
    endfunction

    function automatic int lw_of(input int max_level);
        return width_of(max_level + 1);
    endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; only entries below the current level are ever read.
module simon_seq_mem #(
    parameter int DEPTH = 16,
    parameter int DW    = 2,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon round controller: grows the colour sequence from the PRNG, replays it
// with timed show phases, then checks the player's entries with a per-entry timeout.
module simon_seq_ctrl
    import simon_pkg::*;
#(
    parameter  int NUM_COLORS = 4,
    parameter  int MAX_LEVEL  = 16,
    parameter  int SHOW_ON    = 4,
    parameter  int SHOW_OFF   = 2,
    parameter  int TIMEOUT    = 64,
    localparam int CW         = cw_of(NUM_COLORS),
    localparam int LW         = lw_of(MAX_LEVEL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rnd_req,
    input  logic          rnd_valid,
    input  logic [CW-1:0] rnd_data,
    input  logic          btn_valid,
    input  logic [CW-1:0] btn_color,
    output logic          show_valid,
    output logic [CW-1:0] show_color,
    output logic          player_turn,
    output logic [LW-1:0] level,
    output logic [LW-1:0] score,
    output logic          score_inc,
    output logic          error_led,
    output logic          win_led,
    output logic          timeout
);

    localparam int AW        = width_of(MAX_LEVEL);
    localparam int TW        = width_of(TIMEOUT);
    localparam int PHASE_MAX = (SHOW_ON > SHOW_OFF) ? SHOW_ON : SHOW_OFF;
    localparam int PW        = width_of(PHASE_MAX);

    localparam logic [PW-1:0] ON_LAST      = PW'(SHOW_ON - 1);
    localparam logic [PW-1:0] OFF_LAST     = PW'(SHOW_OFF - 1);
    localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LEVEL_MAX    = LW'(MAX_LEVEL);
    localparam logic [CW:0]   NUM_COLORS_W = (CW + 1)'(NUM_COLORS);

    state_t        state_reg, state_next;
    logic [LW-1:0] level_reg, level_next;
    logic [LW-1:0] score_reg, score_next;
    logic          timeout_reg, timeout_next;
    logic [AW-1:0] show_idx_reg, show_idx_next;
    logic [AW-1:0] in_idx_reg, in_idx_next;
    logic [PW-1:0] phase_reg, phase_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [CW-1:0] btn_reg, btn_next;

    logic          mem_we;
    logic [AW-1:0] mem_raddr;
    logic [CW-1:0] mem_rdata;
    logic [LW-1:0] level_last;

    simon_seq_mem #(
        .DEPTH (MAX_LEVEL),
        .DW    (CW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (AW'(level_reg)),
        .wdata (rnd_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // The replay walks show_idx; the checker walks in_idx.
    assign mem_raddr  = (state_reg == ST_SHOW_ON || state_reg == ST_SHOW_GAP) ?
                        show_idx_reg : in_idx_reg;
    assign level_last = level_reg - LW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            level_reg    <= '0;
            score_reg    <= '0;
            timeout_reg  <= 1'b0;
            show_idx_reg <= '0;
            in_idx_reg   <= '0;
            phase_reg    <= '0;
            timer_reg    <= '0;
            btn_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            level_reg    <= level_next;
            score_reg    <= score_next;
            timeout_reg  <= timeout_next;
            show_idx_reg <= show_idx_next;
            in_idx_reg   <= in_idx_next;
            phase_reg    <= phase_next;
            timer_reg    <= timer_next;
            btn_reg      <= btn_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        level_next    = level_reg;
        score_next    = score_reg;
        timeout_next  = timeout_reg;
        show_idx_next = show_idx_reg;
        in_idx_next   = in_idx_reg;
        phase_next    = phase_reg;
        timer_next    = timer_reg;
        btn_next      = btn_reg;
        mem_we        = 1'b0;

        unique case (state_reg)
            ST_IDLE, ST_WIN, ST_ERROR: begin
                if (start) begin
                    level_next   = '0;
                    score_next   = '0;
                    timeout_next = 1'b0;
                    state_next   = ST_GEN;
                end
            end
            ST_GEN: begin
                // Out-of-range colours from the PRNG are dropped and re-requested.
                if (rnd_valid && ({1'b0, rnd_data} < NUM_COLORS_W)) begin
                    mem_we        = 1'b1;
                    level_next    = (level_reg != LEVEL_MAX) ? level_reg + LW'(1) : level_reg;
                    show_idx_next = '0;
                    phase_next    = '0;
                    state_next    = ST_SHOW_ON;
                end
            end
            ST_SHOW_ON: begin
                if (phase_reg == ON_LAST) begin
                    phase_next = '0;
                    state_next = ST_SHOW_GAP;
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            ST_SHOW_GAP: begin
                if (phase_reg == OFF_LAST) begin
                    phase_next = '0;
                    if (LW'(show_idx_reg) == level_last) begin
                        in_idx_next = '0;
                        timer_next  = '0;
                        state_next  = ST_PLAYER;
                    end else begin
                        show_idx_next = show_idx_reg + AW'(1);
                        state_next    = ST_SHOW_ON;
                    end
                end else begin
                    phase_next = phase_reg + PW'(1);
                end
            end
            ST_PLAYER: begin
                // A press on the last allowed cycle still counts as an entry.
                if (btn_valid) begin
                    btn_next   = btn_color;
                    state_next = ST_CHECK;
                end else if (timer_reg == TIMER_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = ST_ERROR;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            ST_CHECK: begin
                if (btn_reg != mem_rdata) begin
                    timeout_next = 1'b0;
                    state_next   = ST_ERROR;
                end else if (LW'(in_idx_reg) == level_last) begin
                    state_next = ST_LEVEL_UP;
                end else begin
                    in_idx_next = in_idx_reg + AW'(1);
                    timer_next  = '0;
                    state_next  = ST_PLAYER;
                end
            end
            ST_LEVEL_UP: begin
                score_next = (score_reg != LEVEL_MAX) ? score_reg + LW'(1) : score_reg;
                state_next = (level_reg == LEVEL_MAX) ? ST_WIN : ST_GEN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rnd_req     = (state_reg == ST_GEN);
    assign show_valid  = (state_reg == ST_SHOW_ON);
    assign show_color  = show_valid ? mem_rdata : '0;
    assign player_turn = (state_reg == ST_PLAYER);
    assign score_inc   = (state_reg == ST_LEVEL_UP);
    assign error_led   = (state_reg == ST_ERROR);
    assign win_led     = (state_reg == ST_WIN);
    assign level       = level_reg;
    assign score       = score_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Bench for simon_seq_ctrl: a scoreboard queue holds the replay expected after
// each PRNG transfer, and the scenario tasks compare the DUT against it.
module tb_simon_seq_ctrl;

    localparam int NC  = 4;
    localparam int ML  = 3;
    localparam int SON = 2;
    localparam int SOF = 1;
    localparam int TO  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       rnd_valid = 1'b0;
    logic [1:0] rnd_data = '0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_color = '0;
    logic       rnd_req, show_valid, player_turn, score_inc, error_led, win_led, timeout;
    logic [1:0] show_color, level, score;

    // Second instance with three colours, so code 3 is out of range.
    logic       start3 = 1'b0;
    logic       rnd_valid3 = 1'b0;
    logic [1:0] rnd_data3 = '0;
    logic       rnd_req3, show_valid3, player_turn3, score_inc3, error_led3, win_led3, timeout3;
    logic [1:0] show_color3, level3, score3;

    int n_checks = 0;
    int n_fail   = 0;
    int inc_count = 0;
    logic [1:0] seq_model[$];
    logic [1:0] exp_show_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (score_inc) inc_count++;

    simon_seq_ctrl #(.NUM_COLORS(NC), .MAX_LEVEL(ML), .SHOW_ON(SON), .SHOW_OFF(SOF), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .rnd_req(rnd_req), .rnd_valid(rnd_valid),
        .rnd_data(rnd_data), .btn_valid(btn_valid), .btn_color(btn_color),
        .show_valid(show_valid), .show_color(show_color), .player_turn(player_turn),
        .level(level), .score(score), .score_inc(score_inc), .error_led(error_led),
        .win_led(win_led), .timeout(timeout)
    );

    simon_seq_ctrl #(.NUM_COLORS(3), .MAX_LEVEL(ML), .SHOW_ON(SON), .SHOW_OFF(SOF), .TIMEOUT(TO)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .rnd_req(rnd_req3), .rnd_valid(rnd_valid3),
        .rnd_data(rnd_data3), .btn_valid(btn_valid), .btn_color(btn_color),
        .show_valid(show_valid3), .show_color(show_color3), .player_turn(player_turn3),
        .level(level3), .score(score3), .score_inc(score_inc3), .error_led(error_led3),
        .win_led(win_led3), .timeout(timeout3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        step();
        btn_valid = 1'b0;
        step();
        $display("press color=%0d -> player_turn=%0b score_inc=%0b error=%0b", c, player_turn, score_inc, error_led);
    endtask

    // Offers one colour to the main DUT and queues the full replay it should cause.
    task automatic prng_give(input logic [1:0] val);
        int k = 0;
        while (rnd_req !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        n_checks++;
        if (rnd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL gen_rnd_req got %0b want 1", rnd_req);
        end
        rnd_valid = 1'b1;
        rnd_data  = val;
        step();
        rnd_valid = 1'b0;
        seq_model.push_back(val);
        foreach (seq_model[i]) exp_show_q.push_back(seq_model[i]);
        $display("prng give %0d -> rnd_req=%0b level=%0d", val, rnd_req, level);
        n_checks++;
        if (rnd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL gen_req_drop got %0b want 0", rnd_req);
        end
        n_checks++;
        if (level !== 2'(seq_model.size())) begin
            n_fail++;
            $display("FAIL gen_level got %0d want %0d", level, seq_model.size());
        end
    endtask

    task automatic replay_check();
        logic [1:0] exp;
        int k;
        while (exp_show_q.size() > 0) begin
            exp = exp_show_q.pop_front();
            k = 0;
            while (show_valid !== 1'b1 && k < 20) begin
                step();
                k++;
            end
            for (int c = 0; c < SON; c++) begin
                $display("show cycle %0d valid=%0b color=%0d exp=%0d", c, show_valid, show_color, exp);
                n_checks++;
                if (show_valid !== 1'b1 || show_color !== exp) begin
                    n_fail++;
                    $display("FAIL show_on got valid=%0b color=%0d want valid=1 color=%0d", show_valid, show_color, exp);
                end
                step();
            end
            for (int g = 0; g < SOF; g++) begin
                n_checks++;
                if (show_valid !== 1'b0 || show_color !== 2'd0) begin
                    n_fail++;
                    $display("FAIL show_gap got valid=%0b color=%0d want 0/0", show_valid, show_color);
                end
                step();
            end
        end
        n_checks++;
        if (player_turn !== 1'b1) begin
            n_fail++;
            $display("FAIL replay_player_turn got %0b want 1", player_turn);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if ({rnd_req, show_valid, show_color, player_turn, level, score, score_inc, error_led, win_led, timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got nonzero want all 0");
        end
        n_checks++;
        if ({rnd_req3, show_valid3, show_color3, player_turn3, level3, score3, score_inc3, error_led3, win_led3, timeout3} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs3 got nonzero want all 0");
        end
        rst = 1'b1;
        step();
        step();
        $display("reset released: rnd_req=%0b level=%0d score=%0d", rnd_req, level, score);
        n_checks++;
        if ({rnd_req, show_valid, player_turn, level, score, error_led, win_led} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset got nonzero want all 0");
        end
    endtask

    task automatic test_first_level();
        seq_model.delete();
        exp_show_q.delete();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rnd_req !== 1'b1) begin
                n_fail++;
                $display("FAIL req_hold got %0b want 1", rnd_req);
            end
            step();
        end
        prng_give(2'd2);
        replay_check();
        n_checks++;
        if (level !== 2'd1) begin
            n_fail++;
            $display("FAIL first_level got %0d want 1", level);
        end
    endtask

    task automatic test_win();
        int base = inc_count;
        press(2'd2);
        n_checks++;
        if (score_inc !== 1'b1) begin
            n_fail++;
            $display("FAIL lvl1_score_inc got %0b want 1", score_inc);
        end
        step();
        n_checks++;
        if (score !== 2'd1) begin
            n_fail++;
            $display("FAIL lvl1_score got %0d want 1", score);
        end
        prng_give(2'd0);
        replay_check();
        press(2'd2);
        n_checks++;
        if (player_turn !== 1'b1 || score_inc !== 1'b0) begin
            n_fail++;
            $display("FAIL lvl2_mid got turn=%0b inc=%0b want 1/0", player_turn, score_inc);
        end
        press(2'd0);
        step();
        prng_give(2'd3);
        replay_check();
        press(2'd2);
        press(2'd0);
        press(2'd3);
        step();
        $display("win: win_led=%0b score=%0d level=%0d pulses=%0d", win_led, score, level, inc_count - base);
        n_checks++;
        if (win_led !== 1'b1 || score !== 2'd3 || level !== 2'd3) begin
            n_fail++;
            $display("FAIL win_state got win=%0b score=%0d level=%0d want 1/3/3", win_led, score, level);
        end
        n_checks++;
        if (inc_count - base !== 3) begin
            n_fail++;
            $display("FAIL score_inc_pulses got %0d want 3", inc_count - base);
        end
        btn_valid = 1'b1;
        step();
        btn_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (win_led !== 1'b1 || score !== 2'd3) begin
            n_fail++;
            $display("FAIL win_hold got win=%0b score=%0d want 1/3", win_led, score);
        end
    endtask

    task automatic test_error();
        pulse_start();
        seq_model.delete();
        n_checks++;
        if (level !== 2'd0 || score !== 2'd0 || win_led !== 1'b0 || rnd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_win got level=%0d score=%0d win=%0b req=%0b want 0/0/0/1", level, score, win_led, rnd_req);
        end
        prng_give(2'd2);
        replay_check();
        press(2'd2);
        step();
        prng_give(2'd0);
        replay_check();
        press(2'd2);
        press(2'd1);
        n_checks++;
        if (error_led !== 1'b1 || timeout !== 1'b0 || score !== 2'd1) begin
            n_fail++;
            $display("FAIL mismatch_error got err=%0b to=%0b score=%0d want 1/0/1", error_led, timeout, score);
        end
        pulse_start();
        seq_model.delete();
        n_checks++;
        if (level !== 2'd0 || score !== 2'd0 || error_led !== 1'b0 || rnd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_error got level=%0d score=%0d err=%0b req=%0b want 0/0/0/1", level, score, error_led, rnd_req);
        end
        prng_give(2'd1);
    endtask

    task automatic test_timeout();
        replay_check();
        repeat (TO - 1) step();
        n_checks++;
        if (player_turn !== 1'b1 || error_led !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early got turn=%0b err=%0b want 1/0", player_turn, error_led);
        end
        step();
        $display("timeout: error_led=%0b timeout=%0b", error_led, timeout);
        n_checks++;
        if (error_led !== 1'b1 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_error got err=%0b to=%0b want 1/1", error_led, timeout);
        end
        pulse_start();
        seq_model.delete();
        prng_give(2'd3);
        replay_check();
        repeat (TO - 1) step();
        press(2'd3);
        n_checks++;
        if (score_inc !== 1'b1 || error_led !== 1'b0) begin
            n_fail++;
            $display("FAIL last_cycle_press got inc=%0b err=%0b want 1/0", score_inc, error_led);
        end
        step();
    endtask

    task automatic test_reject();
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        rnd_valid3 = 1'b1;
        rnd_data3  = 2'd3;
        step();
        $display("dut3 offer 3 -> rnd_req=%0b level=%0d", rnd_req3, level3);
        n_checks++;
        if (rnd_req3 !== 1'b1 || level3 !== 2'd0 || show_valid3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_out_of_range got req=%0b level=%0d show=%0b want 1/0/0", rnd_req3, level3, show_valid3);
        end
        rnd_data3 = 2'd1;
        step();
        rnd_valid3 = 1'b0;
        $display("dut3 offer 1 -> show=%0b color=%0d level=%0d", show_valid3, show_color3, level3);
        n_checks++;
        if (rnd_req3 !== 1'b0 || level3 !== 2'd1 || show_valid3 !== 1'b1 || show_color3 !== 2'd1) begin
            n_fail++;
            $display("FAIL accept_after_reject got req=%0b level=%0d show=%0b color=%0d want 0/1/1/1", rnd_req3, level3, show_valid3, show_color3);
        end
    endtask

    task automatic test_mid_reset();
        logic [1:0] sc;
        sc = score;
        btn_valid = 1'b1;
        btn_color = 2'd0;
        step();
        btn_valid = 1'b0;
        n_checks++;
        if (rnd_req !== 1'b1 || player_turn !== 1'b0 || score !== sc) begin
            n_fail++;
            $display("FAIL btn_in_gen got req=%0b turn=%0b score=%0d want 1/0/%0d", rnd_req, player_turn, score, sc);
        end
        prng_give(2'd0);
        btn_valid = 1'b1;
        btn_color = 2'd3;
        step();
        btn_valid = 1'b0;
        n_checks++;
        if (show_valid !== 1'b1 || show_color !== 2'd3 || score !== sc) begin
            n_fail++;
            $display("FAIL btn_in_show got show=%0b color=%0d score=%0d want 1/3/%0d", show_valid, show_color, score, sc);
        end
        #2;
        rst = 1'b0;
        #1;
        $display("async reset mid-show: show=%0b level=%0d score=%0d", show_valid, level, score);
        n_checks++;
        if ({rnd_req, show_valid, show_color, player_turn, level, score, score_inc, error_led, win_led, timeout} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got nonzero outputs want all 0");
        end
        n_checks++;
        if ({rnd_req3, show_valid3, show_color3, player_turn3, level3, score3, error_led3, timeout3} !== '0) begin
            n_fail++;
            $display("FAIL async_reset3 got nonzero outputs want all 0");
        end
        exp_show_q.delete();
        step();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({rnd_req, show_valid, player_turn, level, score, score_inc, error_led} !== '0) begin
            n_fail++;
            $display("FAIL after_release got nonzero outputs want all 0");
        end
    endtask

    initial begin
        test_reset();
        test_first_level();
        test_win();
        test_error();
        test_timeout();
        test_reject();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
